// File: rtl/move_list_collector.sv
// move_list_collector
//   Snapshots NUM_CH 32-bit move words on a load strobe, drops empty words and
//   pushes the rest into a first-word fall-through FIFO that a downstream
//   consumer drains through a valid/ready port.
//
//   Optional feature macro: MOVE_COLLECT_CAPTURE_FIRST_EN
//     defined     : two-pass scan (SCAN_CAP, then SCAN); captures leave first.
//     not defined : single pass, words leave in ascending channel order.
//
//   Ports
//     clk         system clock, rising edge
//     clear       asynchronous active-high reset
//     enable      scan advance qualifier
//     load        snapshot strobe, honoured only in IDLE
//     move_bus    NUM_CH packed move words, channel k at [32k+31:32k]
//     busy        high whenever the FSM is not IDLE
//     done        one-cycle pulse when a scan completes
//     move_count  words pushed by the last or current scan
//     out_valid   FIFO non-empty
//     out_ready   consumer accepts out_move
//     out_move    FIFO head word
//     fifo_level  FIFO occupancy
module move_list_collector #(
    parameter int NUM_CH = 16,
    parameter int DEPTH  = 32
) (
    input  logic                         clk,
    input  logic                         clear,
    input  logic                         enable,
    input  logic                         load,
    input  logic [NUM_CH*32-1:0]         move_bus,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(NUM_CH+1)-1:0]  move_count,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_move,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(NUM_CH+1);
    localparam int LW = $clog2(DEPTH+1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CH - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
`ifdef MOVE_COLLECT_CAPTURE_FIRST_EN
        ST_SCAN_CAP = 2'd1,
`endif
        ST_SCAN     = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

`ifdef MOVE_COLLECT_CAPTURE_FIRST_EN
    localparam state_e FIRST_SCAN = ST_SCAN_CAP;
`else
    localparam state_e FIRST_SCAN = ST_SCAN;
`endif

    state_e                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_CH*32-1:0]  snap_q;
    logic [CW-1:0]         move_count_q, move_count_d;
    logic                  busy_q, done_q;

    logic [31:0]           mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         level_q;

    logic [31:0]           cur_word_s;
    logic                  is_empty_s, is_cap_s;
    logic                  scanning_s, eligible_s;
    logic                  full_s, push_s, pop_s, advance_s;

    assign cur_word_s = snap_q[{idx_q, 5'b00000} +: 32];
    assign is_empty_s = (cur_word_s == 32'h0000_0000);
    assign is_cap_s   = (cur_word_s[29:24] != 6'h00);

    assign full_s = (level_q == FULL_LVL);
    assign pop_s  = (level_q != {LW{1'b0}}) && out_ready;

    // Word eligibility depends on which pass the scan is in.
    always_comb begin
        scanning_s = 1'b0;
        eligible_s = 1'b0;
        case (state_q)
`ifdef MOVE_COLLECT_CAPTURE_FIRST_EN
            ST_SCAN_CAP: begin
                scanning_s = 1'b1;
                eligible_s = is_cap_s;
            end
            ST_SCAN: begin
                scanning_s = 1'b1;
                eligible_s = !is_empty_s && !is_cap_s;
            end
`else
            ST_SCAN: begin
                scanning_s = 1'b1;
                eligible_s = !is_empty_s;
            end
`endif
            default: begin
                scanning_s = 1'b0;
                eligible_s = 1'b0;
            end
        endcase
    end

    // A full FIFO refuses the push even when a pop happens the same cycle.
    assign push_s    = scanning_s && enable && eligible_s && !full_s;
    assign advance_s = scanning_s && enable && (!eligible_s || !full_s);

    // Next-state, scan index and move counter.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        move_count_d = move_count_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d      = FIRST_SCAN;
                    idx_d        = {IW{1'b0}};
                    move_count_d = {CW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef MOVE_COLLECT_CAPTURE_FIRST_EN
            ST_SCAN_CAP: begin
                if (advance_s && (idx_q == LAST_IDX)) begin
                    state_d = ST_SCAN;
                    idx_d   = {IW{1'b0}};
                end else if (advance_s) begin
                    idx_d = idx_q + 1'b1;
                end else begin
                    idx_d = idx_q;
                end
            end
`endif
            ST_SCAN: begin
                if (advance_s && (idx_q == LAST_IDX)) begin
                    state_d = ST_DONE;
                end else if (advance_s) begin
                    idx_d = idx_q + 1'b1;
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (push_s) begin
            move_count_d = move_count_q + 1'b1;
        end else begin
            move_count_d = move_count_d;
        end
    end

    // FSM state, snapshot and registered status outputs.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q      <= ST_IDLE;
            idx_q        <= {IW{1'b0}};
            snap_q       <= {(NUM_CH*32){1'b0}};
            move_count_q <= {CW{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            move_count_q <= move_count_d;
            busy_q       <= (state_d != ST_IDLE);
            done_q       <= (state_d == ST_DONE);
            if ((state_q == ST_IDLE) && load) begin
                snap_q <= move_bus;
            end
        end
    end

    // FIFO storage; contents past the read pointer are never observed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= cur_word_s;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            level_q  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign move_count = move_count_q;
    assign fifo_level = level_q;
    assign out_valid  = (level_q != {LW{1'b0}});
    // Head word is forced to zero while empty so the reset value is defined.
    assign out_move   = out_valid ? mem_q[rd_ptr_q] : 32'h0000_0000;

endmodule

// File: tb/tb_move_list_collector.sv
module tb_move_list_collector;

    localparam int NUM_CH = 16;
    localparam int DEPTH  = 4;
`ifdef MOVE_COLLECT_CAPTURE_FIRST_EN
    localparam int SCAN_CYC = 2*NUM_CH + 1;
`else
    localparam int SCAN_CYC = NUM_CH + 1;
`endif

    logic                 clk = 1'b0;
    logic                 clear;
    logic                 enable;
    logic                 load;
    logic [NUM_CH*32-1:0] move_bus;
    logic                 busy, done, out_valid, out_ready;
    logic [4:0]           move_count;
    logic [31:0]          out_move;
    logic [2:0]           fifo_level;

    int n_chk  = 0;
    int n_fail = 0;
    int done_seen = 0;
    logic [31:0] rx_q [$];

    move_list_collector #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
        .clk(clk), .clear(clear), .enable(enable), .load(load),
        .move_bus(move_bus), .busy(busy), .done(done), .move_count(move_count),
        .out_valid(out_valid), .out_ready(out_ready), .out_move(out_move),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Record every accepted word and every done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (!clear && out_valid && out_ready) rx_q.push_back(out_move);
        if (!clear && done) done_seen++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          ch_a;
        logic [31:0] w_a;
        int          ch_b;
        logic [31:0] w_b;
        int          exp_cnt;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs [5];

    // Load one snapshot and wait for done; optionally disturb with a stray
    // load mid-scan and three enable-low cycles.
    task automatic do_scan(input logic [NUM_CH*32-1:0] bus, input bit disturb, output int done_cyc);
        done_cyc = -1;
        rx_q.delete();
        @(negedge clk);
        move_bus = bus;
        load     = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        chk("busy_after_load", 32'(busy), 32'h1);
        for (int k = 1; k <= 200; k++) begin
            if (disturb && k == 3) begin load = 1'b1; move_bus = '1; end
            if (disturb && k == 4) load = 1'b0;
            enable = (disturb && k >= 6 && k <= 8) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            if (done) begin
                done_cyc = k + 1;
                break;
            end
        end
        enable = 1'b1;
        if (done_cyc < 0) begin
            n_fail++;
            $display("FAIL done_timeout: got none expected done pulse");
        end
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'h0);
        chk("busy_after_done", 32'(busy), 32'h0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    int          dc;
    logic [NUM_CH*32-1:0] bus;
    int          seen_before;

    initial begin
        vecs[0] = '{0, 32'h0, 1, 32'h0, 0, 32'h0, 32'h0};
`ifdef MOVE_COLLECT_CAPTURE_FIRST_EN
        vecs[1] = '{0, 32'h001C_1814, 5, 32'h3015_1814, 2, 32'h3015_1814, 32'h001C_1814};
        vecs[2] = '{3, 32'h0000_0001, 15, 32'h3F00_0000, 2, 32'h3F00_0000, 32'h0000_0001};
`else
        vecs[1] = '{0, 32'h001C_1814, 5, 32'h3015_1814, 2, 32'h001C_1814, 32'h3015_1814};
        vecs[2] = '{3, 32'h0000_0001, 15, 32'h3F00_0000, 2, 32'h0000_0001, 32'h3F00_0000};
`endif
        vecs[3] = '{0, 32'h0, 15, 32'h8000_0000, 1, 32'h8000_0000, 32'h0};
        vecs[4] = '{0, 32'h0100_0000, 1, 32'h0000_0100, 2, 32'h0100_0000, 32'h0000_0100};

        clear = 1'b1; enable = 1'b1; load = 1'b0; out_ready = 1'b1; move_bus = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_move_count", 32'(move_count), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_move", out_move, 32'h0);
        chk("rst_fifo_level", 32'(fifo_level), 32'h0);
        repeat (2) @(negedge clk);
        clear = 1'b0;

        // Table-driven scans with the consumer always ready.
        for (int i = 0; i < 5; i++) begin
            bus = '0;
            bus[vecs[i].ch_a*32 +: 32] = vecs[i].w_a;
            bus[vecs[i].ch_b*32 +: 32] = vecs[i].w_b;
            do_scan(bus, 1'b0, dc);
            chk($sformatf("v%0d_done_cycle", i), 32'(dc), 32'(SCAN_CYC));
            chk($sformatf("v%0d_move_count", i), 32'(move_count), 32'(vecs[i].exp_cnt));
            chk($sformatf("v%0d_rx_count", i), 32'(rx_q.size()), 32'(vecs[i].exp_cnt));
            if (vecs[i].exp_cnt >= 1)
                chk($sformatf("v%0d_word0", i), (rx_q.size() > 0) ? rx_q[0] : 32'hDEAD_BEEF, vecs[i].exp0);
            if (vecs[i].exp_cnt >= 2)
                chk($sformatf("v%0d_word1", i), (rx_q.size() > 1) ? rx_q[1] : 32'hDEAD_BEEF, vecs[i].exp1);
            chk($sformatf("v%0d_out_valid_idle", i), 32'(out_valid), 32'h0);
        end

        // Stray load mid-scan is ignored; three enable-low cycles add three cycles.
        bus = '0;
        bus[0*32 +: 32] = 32'h001C_1814;
        bus[5*32 +: 32] = 32'h3015_1814;
        do_scan(bus, 1'b1, dc);
        chk("dist_done_cycle", 32'(dc), 32'(SCAN_CYC + 3));
        chk("dist_move_count", 32'(move_count), 32'h2);
        chk("dist_rx_count", 32'(rx_q.size()), 32'h2);
        chk("dist_word0", (rx_q.size() > 0) ? rx_q[0] : 32'hDEAD_BEEF, vecs[1].exp0);
        chk("dist_word1", (rx_q.size() > 1) ? rx_q[1] : 32'hDEAD_BEEF, vecs[1].exp1);

        // Back-pressure: 16 capture words through a 4-deep FIFO.
        rx_q.delete();
        for (int k = 0; k < NUM_CH; k++) bus[k*32 +: 32] = 32'h0100_0000 | 32'(k);
        @(negedge clk);
        out_ready = 1'b0; move_bus = bus; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("bp_level_sat", 32'(fifo_level), 32'h4);
        chk("bp_busy", 32'(busy), 32'h1);
        chk("bp_head", out_move, 32'h0100_0000);
        @(posedge clk); #1;
        chk("bp_head_stable", out_move, 32'h0100_0000);
        chk("bp_level_hold", 32'(fifo_level), 32'h4);
        out_ready = 1'b1;
        dc = -1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (done) begin dc = k; break; end
        end
        if (dc < 0) begin
            n_fail++;
            $display("FAIL bp_done_timeout: got none expected done pulse");
        end
        repeat (8) @(posedge clk);
        #1;
        chk("bp_move_count", 32'(move_count), 32'd16);
        chk("bp_rx_count", 32'(rx_q.size()), 32'd16);
        for (int k = 0; k < NUM_CH; k++)
            chk($sformatf("bp_word%0d", k), (rx_q.size() > k) ? rx_q[k] : 32'hDEAD_BEEF,
                32'h0100_0000 | 32'(k));

        // Asynchronous clear mid-scan with three words buffered.
        bus = '0;
        for (int k = 0; k < 5; k++) bus[k*32 +: 32] = 32'h0200_0000 | 32'(k);
        @(negedge clk);
        out_ready = 1'b0; move_bus = bus; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (fifo_level == 3'd3) break;
            @(posedge clk); #1;
        end
        chk("clr_level3_reached", 32'(fifo_level), 32'h3);
        seen_before = done_seen;
        #2 clear = 1'b1;
        #1;
        chk("clr_busy", 32'(busy), 32'h0);
        chk("clr_done", 32'(done), 32'h0);
        chk("clr_move_count", 32'(move_count), 32'h0);
        chk("clr_out_valid", 32'(out_valid), 32'h0);
        chk("clr_out_move", out_move, 32'h0);
        chk("clr_fifo_level", 32'(fifo_level), 32'h0);
        @(negedge clk);
        @(negedge clk);
        clear = 1'b0; out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("clr_no_done", 32'(done_seen), 32'(seen_before));
        chk("clr_idle", 32'(busy), 32'h0);

        bus = '0;
        bus[0*32 +: 32] = 32'h001C_1814;
        bus[5*32 +: 32] = 32'h3015_1814;
        do_scan(bus, 1'b0, dc);
        chk("post_clr_done_cycle", 32'(dc), 32'(SCAN_CYC));
        chk("post_clr_rx_count", 32'(rx_q.size()), 32'h2);
        chk("post_clr_word0", (rx_q.size() > 0) ? rx_q[0] : 32'hDEAD_BEEF, vecs[1].exp0);
        chk("post_clr_word1", (rx_q.size() > 1) ? rx_q[1] : 32'hDEAD_BEEF, vecs[1].exp1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/move_list_collector.md
# move_list_collector

Parametrised move-list serializer between the square array and the search/ordering logic. On a `load` strobe it snapshots NUM_CH 32-bit move words (one per square direction/knight channel), discards empty words, and pushes the remaining moves into an internal FIFO. Downstream consumers drain the FIFO through a valid/ready port. It generalises the fixed two-square, sixteen-output arrangement to any channel count, adds buffering and back-pressure, and adds optional capture-first ordering.

## Interface

Parameters:
- NUM_CH, 16: number of 32-bit move channels on `move_bus`; must be ≥1.
- DEPTH, 32: FIFO depth in move words; must be a power of two and ≥2.

Ports:
- clk  in  1  system clock; all state is rising-edge.
- clear  in  1  asynchronous, active-high reset.
- enable  in  1  scan advance qualifier; while low, the scan index holds and no push occurs.
- load  in  1  snapshot strobe; sampled only in IDLE.
- move_bus  in  NUM_CH*32  channel k occupies bits [32k+31:32k].
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a scan completes.
- move_count  out  $clog2(NUM_CH+1)  number of words pushed by the last or current scan.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts `out_move` when `out_valid && out_ready`.
- out_move  out  32  FIFO head word.
- fifo_level  out  $clog2(DEPTH+1)  current occupancy.

## Operation

- Move word fields: [29:24] captured piece, [21:16] final position, [13:8] initial piece, [5:0] initial position. Other bits pass through unchanged.
- Empty word: all 32 bits are zero. Capture word: non-empty with [29:24] ≠ 0. Quiet word: non-empty with [29:24] = 0.
- States: IDLE, SCAN_CAP (exists only with the macro), SCAN, DONE.
- IDLE + `load`:
  - Latch `move_bus` into the snapshot register.
  - idx←0, move_count←0.
  - Next state is SCAN_CAP when the macro is defined, otherwise SCAN.
- A scan cycle (`enable`=1) examines snapshot[idx]:
  - Eligible word and FIFO not full: push it, increment move_count, advance idx.
  - Eligible word and FIFO full: stall, with idx held.
  - Ineligible word: advance idx with no push.
- Eligibility:
  - SCAN_CAP: capture words only.
  - SCAN: quiet words only when the macro is defined, otherwise all non-empty words.
- When idx = NUM_CH-1 advances:
  - SCAN_CAP moves to SCAN with idx←0.
  - SCAN moves to DONE.
- DONE: `done`=1 for one cycle, then IDLE. move_count holds until the next accepted `load`.
- `load` outside IDLE is ignored. The snapshot is not updated mid-scan.
- FIFO: synchronous, first-word fall-through.
  - Pop when `out_valid && out_ready`.
  - Push and pop in the same cycle are both honoured when not full.
  - When full, push is refused even if a pop occurs that cycle, so the stall lasts one extra cycle.
  - Pointers wrap modulo DEPTH.
  - `out_move` is stable while `out_valid && !out_ready`.
- FIFO draining is independent of the FSM and continues in IDLE.

## Timing

- Reset values (`clear`=1, asynchronous):
  - State IDLE; idx 0; snapshot 0.
  - FIFO emptied: pointers 0, fifo_level 0.
  - busy 0, done 0, move_count 0, out_valid 0, out_move 32'h0.
- Reset mid-scan aborts the scan and discards all buffered words. No `done` is produced.
- `load` sampled at edge N: busy=1 from N+1, and the first scan cycle is N+1.
- A word pushed at edge M gives out_valid=1 and out_move=word from M+1 when the FIFO was empty.
- Scan duration with no stalls and `enable`=1:
  - NUM_CH cycles without the macro, 2·NUM_CH cycles with it.
  - `done` is asserted the cycle after the last scan cycle.
  - busy drops the cycle after `done`.
- Every stalled or `enable`=0 cycle adds exactly one cycle.

## Configuration

- MOVE_COLLECT_CAPTURE_FIRST_EN defined: two-pass scan (SCAN_CAP then SCAN). All capture words leave before all quiet words; channel order is preserved within each class.
- Not defined: single pass with no SCAN_CAP state. Words are emitted in ascending channel order regardless of capture status.

## Test plan

- Reset: NUM_CH=16, `load` with all-zero bus, out_ready=1 → no push, move_count=0, `done` pulses at cycle 17 after load, out_valid stays 0.
- Order (macro off): ch0=32'h001C_1814, ch5=32'h3015_1814, others 0, out_ready=1 → out_move sequence 001C_1814 then 3015_1814, move_count=2.
- Capture-first (macro on): same bus → sequence 3015_1814 then 001C_1814, `done` 33 cycles after load.
- Back-pressure: DEPTH=4, 16 non-zero words, out_ready=0 → fifo_level saturates at 4 and busy stays 1. Raise out_ready: all 16 words arrive in channel order with no loss or duplication, move_count=16.
- Ignored load / enable: pulse `load` with a different bus mid-scan → output unchanged. Hold `enable`=0 for 3 cycles → `done` delayed exactly 3 cycles.
- Async clear mid-scan with fifo_level=3 → outputs return to reset values immediately and no `done` occurs. A subsequent `load` works normally.
